spi_frame_receiver: RTL and testbench

SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

---
 rtl/spi_frame_pkg.sv | 18 +
 rtl/bit_synchronizer.sv | 34 +++
 rtl/spi_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_spi_frame_receiver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame receiver.
// Holds the frame geometry and the receive FSM state type.
// No ports; imported by spi_frame_receiver.
// Optional build macro used by the top: SPI_FRAME_ERR_EN (enables err_count).
package spi_frame_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous single-bit input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; all stages load RST_VAL
//   d     - raw asynchronous input
//   q     - synchronised output (last stage)
module bit_synchronizer #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI slave frame receiver: captures 16-bit frames {rw, addr[6:0], data[7:0]}
// sent MSB first on COPI, sampled on rising SCLK while nCS is low. All raw SPI
// inputs are synchronised into the clk domain before use.
// Ports:
//   clk, rst_n            - system clock, asynchronous active-low reset
//   SCLK, COPI, nCS       - raw asynchronous SPI inputs
//   frame_valid           - one-clk pulse when a complete 16-bit frame lands
//   frame_rw/addr/data    - fields of the last valid frame (held)
//   busy                  - receiver is inside a frame
//   err_count             - saturating count of malformed frames
// Build macro: SPI_FRAME_ERR_EN enables err_count; otherwise it is tied to 0.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              COPI,
  input  logic              nCS,
  output logic              frame_valid,
  output logic              frame_rw,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              busy,
  output logic [7:0]        err_count
);

  logic sclk_s;
  logic copi_s;
  logic ncs_s;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(COPI), .q(copi_s)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(nCS), .q(ncs_s)
  );

  logic sclk_hist_q, sclk_hist_d;
  logic ncs_hist_q,  ncs_hist_d;
  logic sclk_rise, ncs_fall, ncs_rise;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  always_comb begin
    sclk_hist_d = sclk_s;
    ncs_hist_d  = ncs_s;
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    frame_ok_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // SCLK edges coinciding with the nCS fall are dropped: IDLE never shifts.
        if (ncs_fall) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      RECV: begin
        // nCS rise takes priority over a simultaneous SCLK rise.
        if (ncs_rise) begin
          state_d    = IDLE;
          frame_ok_d = (cnt_q == CNT_W'(FRAME_BITS));
        end else if (sclk_rise) begin
          if (cnt_q == CNT_W'(FRAME_BITS)) begin
            state_d = OVER;
          end else begin
            shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      OVER: begin
        if (ncs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame outputs update one cycle after the FSM accepts the frame.
    frame_valid_d = frame_ok_q;
    frame_d       = frame_ok_q ? shift_q : frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_hist_q   <= 1'b0;
      ncs_hist_q    <= 1'b1;
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      frame_ok_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_q       <= '0;
    end else begin
      sclk_hist_q   <= sclk_hist_d;
      ncs_hist_q    <= ncs_hist_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      frame_ok_q    <= frame_ok_d;
      frame_valid_q <= frame_valid_d;
      frame_q       <= frame_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_rw    = frame_q[FRAME_BITS-1];
  assign frame_addr  = frame_q[FRAME_BITS-2:DATA_W];
  assign frame_data  = frame_q[DATA_W-1:0];
  assign busy        = (state_q != IDLE);

`ifdef SPI_FRAME_ERR_EN
  logic [7:0] err_q, err_d;
  logic       err_inc;

  always_comb begin
    err_inc = ncs_rise &&
              (((state_q == RECV) && (cnt_q != CNT_W'(FRAME_BITS))) || (state_q == OVER));
    err_d   = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Testbench for spi_frame_receiver. Two instances (SYNC_STAGES 2 and 3) share
// the same SPI stimulus. Expected frames are queued when a frame is sent and a
// monitor pops/compares whenever frame_valid is seen.
// Honours SPI_FRAME_ERR_EN for the expected err_count.
module tb_spi_frame_receiver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SCLK  = 1'b0;
  logic COPI  = 1'b0;
  logic nCS   = 1'b1;

  logic       fv, rw, busy;
  logic [6:0] addr;
  logic [7:0] data, err;
  logic       fv3, rw3, busy3;
  logic [6:0] addr3;
  logic [7:0] data3, err3;

  always #5 clk = ~clk;

  spi_frame_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .frame_valid(fv), .frame_rw(rw), .frame_addr(addr), .frame_data(data),
    .busy(busy), .err_count(err)
  );

  spi_frame_receiver #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .frame_valid(fv3), .frame_rw(rw3), .frame_addr(addr3), .frame_data(data3),
    .busy(busy3), .err_count(err3)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp3_q[$];
  logic [15:0] last_frame = '0;
  int exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference rule: a frame is good iff exactly 16 SCLK rises occur while nCS
  // is low; good frames update the visible fields, anything else is an error.
  function automatic void model_frame(input int nbits, input logic [31:0] bits);
    logic [15:0] v;
    v = bits[15:0];
    if (nbits == 16) begin
      exp_q.push_back(v);
      exp3_q.push_back(v);
      last_frame = v;
    end else begin
`ifdef SPI_FRAME_ERR_EN
      if (exp_err < 255) exp_err++;
`endif
    end
  endfunction

  task automatic send(input int nbits, input logic [31:0] bits);
    int h;
    int lat2;
    int lat3;
    h = $urandom_range(4, 7);
    @(negedge clk);
    nCS = 1'b0;
    wait_clk(h);
    chk("busy_in_frame", busy, 1);
    chk("busy3_in_frame", busy3, 1);
    for (int i = nbits - 1; i >= 0; i--) begin
      COPI = (i < 32) ? bits[i] : 1'b0;
      wait_clk(h);
      SCLK = 1'b1;
      wait_clk(h);
      SCLK = 1'b0;
    end
    wait_clk(h);
    model_frame(nbits, bits);
    nCS  = 1'b1;
    lat2 = 0;
    lat3 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (lat2 == 0 && fv)  lat2 = i;
      if (lat3 == 0 && fv3) lat3 = i;
    end
    chk("latency_sync2", lat2, (nbits == 16) ? 4 : 0);
    chk("latency_sync3", lat3, (nbits == 16) ? 5 : 0);
    chk("err_count", err, exp_err);
    chk("err_count3", err3, exp_err);
    chk("held_frame", {rw, addr, data}, last_frame);
    chk("busy_after", busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", fv, 0);
    chk("rst_frame", {rw, addr, data}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst3_all", {fv3, rw3, addr3, data3, busy3, err3}, 0);
  endtask

  // Monitor: compare every frame_valid pulse against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fv) begin
        if (exp_q.size() == 0) chk("unexpected_valid", fv, 0);
        else chk("frame", {rw, addr, data}, exp_q.pop_front());
      end
      if (fv3) begin
        if (exp3_q.size() == 0) chk("unexpected_valid3", fv3, 0);
        else chk("frame3", {rw3, addr3, data3}, exp3_q.pop_front());
      end
    end
  end

  initial begin
    int nb;
    wait_clk(4);
    chk_reset_outputs();
    rst_n = 1'b1;
    wait_clk(10);

    send(16, 32'h8155);
    send(15, 32'h1234);
    send(17, 32'h1ABCD);
    send(16, 32'h0230);

    for (int k = 0; k < 40; k++) begin
      nb = ($urandom_range(0, 2) != 0) ? 16 : int'($urandom_range(0, 20));
      send(nb, $urandom);
    end

    // Reset in the middle of a frame: partial bits must be discarded.
    @(negedge clk);
    nCS = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 8; i++) begin
      COPI = i[0];
      wait_clk(5);
      SCLK = 1'b1;
      wait_clk(5);
      SCLK = 1'b0;
    end
    rst_n = 1'b0;
    nCS   = 1'b1;
    wait_clk(3);
    chk_reset_outputs();
    last_frame = '0;
    exp_err    = 0;
    rst_n = 1'b1;
    wait_clk(10);
    chk("post_reset_frame", {rw, addr, data}, 0);
    send(16, 32'h9AFF);

    // Many malformed frames drive err_count into saturation.
    for (int k = 0; k < 300; k++) begin
      send(0, 32'h0);
    end
    send(16, 32'h5A3C);

    wait_clk(20);
    chk("queue_drained", exp_q.size(), 0);
    chk("queue3_drained", exp3_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    bad++;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
